// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receiver oversampling stage.
package uart_rx_pkg;

  localparam logic [4:0] PRESCALE_8          = 5'd8;
  localparam logic [4:0] PRESCALE_16         = 5'd16;
  localparam int         EDGE_CNT_W          = 4;
  localparam int         BIT_CNT_W_DEFAULT   = 5;
  localparam logic       IDLE_LEVEL          = 1'b1;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Only x8 is honoured; every other request falls back to x16.
  function automatic logic [4:0] decode_prescale(input logic [4:0] p);
    return (p == PRESCALE_8) ? PRESCALE_8 : PRESCALE_16;
  endfunction

  function automatic logic not_unanimous(input logic [2:0] s);
    return (s != 3'b000) && (s != 3'b111);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchroniser with a configurable reset level; STAGES=0 is a plain wire.
module uart_rx_sync
  import uart_rx_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = IDLE_LEVEL
) (
  input  logic clk,
  input  logic asy_reset,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_flops
      logic [STAGES-1:0] sync_r;

      // shift chain, stage 0 samples the raw line
      always_ff @(posedge clk or negedge asy_reset) begin
        if (!asy_reset) begin
          sync_r <= {STAGES{RESET_VAL}};
        end else begin
          sync_r[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
          end
        end
      end

      assign q = sync_r[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX oversampling edge/bit counter and 3-sample majority bit recovery.
// Optional glitch flag enabled with macro UART_RX_SAMPLER_GLITCH_FLAG_EN.
module uart_rx_edge_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BIT_CNT_W   = BIT_CNT_W_DEFAULT
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  RX_IN,
  input  logic [4:0]            prescale,
  input  logic                  edge_bit_enable,
  input  logic                  data_sampler_enable,
  output logic                  rx_sync,
  output logic [EDGE_CNT_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  sample_glitch
);

  localparam logic [BIT_CNT_W-1:0] BIT_MAX = {BIT_CNT_W{1'b1}};
  localparam logic [BIT_CNT_W-1:0] BIT_ONE = BIT_CNT_W'(1'b1);

  logic                  en_d_r;
  logic [4:0]            p_reg;
  logic [4:0]            p_next_s;
  logic [4:0]            half_s;
  logic [4:0]            edge_ext_s;
  logic                  at_wrap_s;
  logic                  at_s0_s;
  logic                  at_s1_s;
  logic                  at_s2_s;
  logic [EDGE_CNT_W-1:0] edge_count_s;
  logic [BIT_CNT_W-1:0]  bit_count_s;
  logic [2:0]            samples_r;
  logic [2:0]            samples_s;
  logic                  s0_ok_r;
  logic                  s0_ok_s;
  logic                  s1_ok_r;
  logic                  s1_ok_s;
  logic                  sampled_bit_s;
  logic                  sample_valid_s;
`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
  logic                  sample_glitch_s;
`endif

  uart_rx_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (IDLE_LEVEL)
  ) u_rx_sync (
    .clk       (clk_based_on_prescale),
    .asy_reset (asy_reset),
    .d         (RX_IN),
    .q         (rx_sync)
  );

  assign half_s     = {1'b0, p_reg[4:1]};
  assign edge_ext_s = {1'b0, edge_count};
  assign at_wrap_s  = (edge_ext_s == (p_reg - 5'd1));
  assign at_s0_s    = (edge_ext_s == (half_s - 5'd1));
  assign at_s1_s    = (edge_ext_s == half_s);
  assign at_s2_s    = (edge_ext_s == (half_s + 5'd1));

  // prescale is captured only on the enable rising edge
  always_comb begin
    p_next_s = p_reg;
    if (edge_bit_enable && !en_d_r) begin
      p_next_s = decode_prescale(prescale);
    end else begin
      p_next_s = p_reg;
    end
  end

  // edge/bit counters: clear while disabled, bit_count saturates
  always_comb begin
    edge_count_s = edge_count;
    bit_count_s  = bit_count;
    if (!edge_bit_enable) begin
      edge_count_s = '0;
      bit_count_s  = '0;
    end else if (at_wrap_s) begin
      edge_count_s = '0;
      bit_count_s  = (bit_count == BIT_MAX) ? BIT_MAX : (bit_count + BIT_ONE);
    end else begin
      edge_count_s = edge_count + EDGE_CNT_W'(1'b1);
    end
  end

  // majority sampler; ok flags ensure all three samples belong to one enabled window
  always_comb begin
    samples_s      = samples_r;
    s0_ok_s        = s0_ok_r;
    s1_ok_s        = s1_ok_r;
    sampled_bit_s  = sampled_bit;
    sample_valid_s = 1'b0;
`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
    sample_glitch_s = 1'b0;
`endif
    if (edge_bit_enable && data_sampler_enable) begin
      if (at_s0_s) begin
        samples_s[0] = rx_sync;
        s0_ok_s      = 1'b1;
        s1_ok_s      = 1'b0;
      end else if (at_s1_s) begin
        samples_s[1] = rx_sync;
        s1_ok_s      = s0_ok_r;
      end else if (at_s2_s) begin
        samples_s[2] = rx_sync;
        s0_ok_s      = 1'b0;
        s1_ok_s      = 1'b0;
        if (s1_ok_r) begin
          sampled_bit_s  = majority3({rx_sync, samples_r[1:0]});
          sample_valid_s = 1'b1;
`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
          sample_glitch_s = not_unanimous({rx_sync, samples_r[1:0]});
`endif
        end else begin
          sample_valid_s = 1'b0;
        end
      end else begin
        samples_s = samples_r;
      end
    end else begin
      s0_ok_s = 1'b0;
      s1_ok_s = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      en_d_r       <= 1'b0;
      p_reg        <= PRESCALE_16;
      edge_count   <= '0;
      bit_count    <= '0;
      samples_r    <= 3'b111;
      s0_ok_r      <= 1'b0;
      s1_ok_r      <= 1'b0;
      sampled_bit  <= IDLE_LEVEL;
      sample_valid <= 1'b0;
    end else begin
      en_d_r       <= edge_bit_enable;
      p_reg        <= p_next_s;
      edge_count   <= edge_count_s;
      bit_count    <= bit_count_s;
      samples_r    <= samples_s;
      s0_ok_r      <= s0_ok_s;
      s1_ok_r      <= s1_ok_s;
      sampled_bit  <= sampled_bit_s;
      sample_valid <= sample_valid_s;
    end
  end

`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
  // glitch flag, meaningful only alongside sample_valid
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      sample_glitch <= 1'b0;
    end else begin
      sample_glitch <= sample_glitch_s;
    end
  end
`else
  assign sample_glitch = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Scoreboard bench for uart_rx_edge_bit_sampler (SYNC_STAGES=2).
module tb_uart_rx_edge_bit_sampler;

  logic       clk_based_on_prescale = 1'b0;
  logic       asy_reset;
  logic       RX_IN;
  logic [4:0] prescale;
  logic       edge_bit_enable;
  logic       data_sampler_enable;
  logic       rx_sync;
  logic [3:0] edge_count;
  logic [4:0] bit_count;
  logic       sampled_bit;
  logic       sample_valid;
  logic       sample_glitch;

  typedef struct {
    logic       bit_v;
    logic       glitch;
    logic [3:0] ec;
  } sb_item_t;

  sb_item_t sb_q[$];
  logic     want[$];
  logic     dse_q[$];
  sb_item_t mon_exp;
  int       n_checks = 0;
  int       n_fail   = 0;

  always #5 clk_based_on_prescale = ~clk_based_on_prescale;

  uart_rx_edge_bit_sampler #(
    .SYNC_STAGES (2),
    .BIT_CNT_W   (5)
  ) dut (
    .clk_based_on_prescale (clk_based_on_prescale),
    .asy_reset             (asy_reset),
    .RX_IN                 (RX_IN),
    .prescale              (prescale),
    .edge_bit_enable       (edge_bit_enable),
    .data_sampler_enable   (data_sampler_enable),
    .rx_sync               (rx_sync),
    .edge_count            (edge_count),
    .bit_count             (bit_count),
    .sampled_bit           (sampled_bit),
    .sample_valid          (sample_valid),
    .sample_glitch         (sample_glitch)
  );

  // Monitor: every valid pulse must match the head of the scoreboard
  always @(negedge clk_based_on_prescale) begin
    if (sample_valid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid t=%0t got bit=%b ec=%0d required no pulse", $time, sampled_bit, edge_count);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({sampled_bit, sample_glitch, edge_count} !== {mon_exp.bit_v, mon_exp.glitch, mon_exp.ec}) begin
          n_fail++;
          $display("FAIL sample t=%0t got bit=%b glitch=%b ec=%0d required bit=%b glitch=%b ec=%0d",
                   $time, sampled_bit, sample_glitch, edge_count, mon_exp.bit_v, mon_exp.glitch, mon_exp.ec);
        end
      end
    end else if (asy_reset === 1'b1) begin
      n_checks++;
      if (sample_glitch !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_idle t=%0t got %b required 0", $time, sample_glitch);
      end
    end
  end

  function automatic logic want_at(input int i);
    return (i < want.size()) ? want[i] : 1'b1;
  endfunction

  function automatic logic dse_at(input int i);
    return (i < dse_q.size()) ? dse_q[i] : 1'b0;
  endfunction

  task automatic step();
    @(posedge clk_based_on_prescale);
    #1;
  endtask

  task automatic check_counters(input string name, input int exp_ec, input int exp_bc);
    n_checks++;
    if (edge_count !== 4'(exp_ec) || bit_count !== 5'(exp_bc)) begin
      n_fail++;
      $display("FAIL %s got ec=%0d bc=%0d required ec=%0d bc=%0d", name, edge_count, bit_count, exp_ec, exp_bc);
    end
  endtask

  // One enabled frame of ncyc cycles; rx_sync in cycle k equals want[k].
  task automatic run_frame(input string name, input logic [4:0] p_in, input logic [4:0] p_mid,
                           input int mid_at, input int ncyc);
    int         eff_p = (p_in == 5'd8) ? 8 : 16;
    int         h     = eff_p / 2;
    int         i0;
    logic [2:0] s;
    logic       g;
    for (int b = 0; b * eff_p + h + 2 <= ncyc; b++) begin
      i0 = b * eff_p + h - 1;
      s  = {want_at(i0 + 2), want_at(i0 + 1), want_at(i0)};
`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
      g = (s != 3'b000) && (s != 3'b111);
`else
      g = 1'b0;
`endif
      if (dse_at(i0) && dse_at(i0 + 1) && dse_at(i0 + 2))
        sb_q.push_back('{bit_v: ((32'(s[0]) + 32'(s[1]) + 32'(s[2])) >= 2), glitch: g, ec: 4'(h + 2)});
    end
    prescale            = (p_in == 5'd8) ? 5'd16 : 5'd8;
    edge_bit_enable     = 1'b0;
    data_sampler_enable = 1'b0;
    RX_IN = want_at(0);
    step();
    RX_IN = want_at(1);
    step();
    for (int k = 0; k < ncyc; k++) begin
      check_counters(name, k % eff_p, (k / eff_p > 31) ? 31 : k / eff_p);
      prescale            = (k >= mid_at) ? p_mid : p_in;
      edge_bit_enable     = 1'b1;
      data_sampler_enable = dse_at(k);
      RX_IN               = want_at(k + 2);
      step();
    end
    check_counters({name, "_end"}, ncyc % eff_p, (ncyc / eff_p > 31) ? 31 : ncyc / eff_p);
    edge_bit_enable     = 1'b0;
    data_sampler_enable = 1'b0;
    step();
    check_counters({name, "_clear"}, 0, 0);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending got %0d outstanding samples required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic fill(input int n, input logic v, input logic d);
    want.delete();
    dse_q.delete();
    for (int i = 0; i < n; i++) begin
      want.push_back(v);
      dse_q.push_back(d);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({rx_sync, edge_count, bit_count, sampled_bit, sample_valid, sample_glitch} !== {1'b1, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s got rx_sync=%b ec=%0d bc=%0d bit=%b valid=%b glitch=%b required 1 0 0 1 0 0",
               name, rx_sync, edge_count, bit_count, sampled_bit, sample_valid, sample_glitch);
    end
  endtask

  task automatic test_reset();
    asy_reset = 1'b0; RX_IN = 1'b0; prescale = 5'd16;
    edge_bit_enable = 1'b0; data_sampler_enable = 1'b0;
    repeat (3) step();
    check_reset_values("reset_state");
    asy_reset = 1'b1;
    step();
    n_checks++;
    if (rx_sync !== 1'b1) begin n_fail++; $display("FAIL sync_lat1 got %b required 1", rx_sync); end
    step();
    n_checks++;
    if (rx_sync !== 1'b0) begin n_fail++; $display("FAIL sync_lat2 got %b required 0", rx_sync); end
    RX_IN = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_edge_count();
    fill(0, 1'b1, 1'b0);
    run_frame("p8_count", 5'd8, 5'd8, 1000, 24);
  endtask

  task automatic test_sample_clean();
    fill(16, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin want.push_back(1'b1); dse_q.push_back(1'b1); end
    run_frame("p16_clean", 5'd16, 5'd16, 1000, 32);
  endtask

  task automatic test_sample_glitch();
    fill(32, 1'b1, 1'b1);
    want[7] = 1'b0; want[9] = 1'b0;
    want[25] = 1'b0;
    run_frame("p16_glitch", 5'd16, 5'd16, 1000, 32);
  endtask

  task automatic test_sample_p8_random();
    logic v;
    want.delete(); dse_q.delete();
    for (int b = 0; b < 4; b++) begin
      v = 1'($urandom_range(1, 0));
      for (int i = 0; i < 8; i++) begin want.push_back(v); dse_q.push_back(1'b1); end
    end
    want[2 * 8 + 4] = ~want[2 * 8 + 4];
    run_frame("p8_random", 5'd8, 5'd8, 1000, 32);
  endtask

  task automatic test_sampler_drop();
    fill(16, 1'b0, 1'b1);
    for (int i = 8; i < 16; i++) dse_q[i] = 1'b0;
    for (int i = 0; i < 16; i++) begin want.push_back(1'b1); dse_q.push_back(1'b1); end
    run_frame("dse_drop", 5'd16, 5'd16, 1000, 32);
  endtask

  task automatic test_prescale_change();
    fill(0, 1'b1, 1'b0);
    run_frame("p_change", 5'd16, 5'd8, 5, 40);
    run_frame("p_relatch", 5'd8, 5'd8, 1000, 20);
    run_frame("p_illegal", 5'd12, 5'd12, 1000, 34);
  endtask

  task automatic test_bit_saturation();
    fill(0, 1'b1, 1'b0);
    run_frame("bc_sat", 5'd8, 5'd8, 1000, 8 * 33 + 3);
  endtask

  task automatic test_enable_drop_reset();
    fill(16, 1'b0, 1'b1);
    run_frame("en_drop", 5'd16, 5'd16, 1000, 8);
    repeat (4) step();
    n_checks++;
    if (sampled_bit !== 1'b1) begin n_fail++; $display("FAIL en_drop_hold got %b required 1", sampled_bit); end
    RX_IN = 1'b0; prescale = 5'd16;
    repeat (2) step();
    sb_q.push_back('{bit_v: 1'b0, glitch: 1'b0, ec: 4'd10});
    edge_bit_enable = 1'b1; data_sampler_enable = 1'b1;
    repeat (12) step();
    check_counters("pre_reset", 12, 0);
    #2;
    asy_reset = 1'b0;
    #1;
    check_reset_values("mid_frame_reset");
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL pre_reset_sample got %0d pending required 0", sb_q.size()); sb_q.delete(); end
    edge_bit_enable = 1'b0; data_sampler_enable = 1'b0; RX_IN = 1'b1;
    step();
    asy_reset = 1'b1;
    repeat (3) step();
    check_reset_values("post_reset_idle");
  endtask

  initial begin
    test_reset();
    test_edge_count();
    test_sample_clean();
    test_sample_glitch();
    test_sample_p8_random();
    test_sampler_drop();
    test_prescale_change();
    test_bit_saturation();
    test_enable_drop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_edge_bit_sampler.md
Name: uart_rx_edge_bit_sampler

Overview:
Oversampling timing and sampling stage of the UART receiver. It sits directly upstream of the RX control FSM and supplies it with edge_count and bit_count. It synchronises RX_IN and recovers each serial bit by a 3-sample majority vote around the bit centre. The recovered bit goes to the deserializer and the start/parity/stop checkers.

Parameters:
SYNC_STAGES, 2, number of RX_IN synchroniser flops; 0 means bypass (RX_IN used directly).
BIT_CNT_W, 5, width of bit_count; matches the FSM bit_count input.

Ports:
clk_based_on_prescale  input  1  oversampling clock (prescale x baud).
asy_reset  input  1  asynchronous, active-low reset.
RX_IN  input  1  raw serial line; idle high.
prescale  input  5  oversampling ratio; only 8 and 16 are legal.
edge_bit_enable  input  1  from FSM; counters run while high, clear while low.
data_sampler_enable  input  1  from FSM; enables majority sampling.
rx_sync  output  1  synchronised RX_IN.
edge_count  output  4  oversample tick index within the current bit, 0..prescale-1.
bit_count  output  5  number of completed bit periods since enable.
sampled_bit  output  1  majority-voted bit value.
sample_valid  output  1  one-cycle pulse; sampled_bit has just been updated.
sample_glitch  output  1  the three samples were not unanimous (see Optional Feature).

Behaviour:
- Reset (asy_reset=0, async):
  - rx_sync=1; all synchroniser flops set to 1.
  - edge_count=0, bit_count=0, sampled_bit=1, sample_valid=0, sample_glitch=0.
  - Internal sample regs = 3'b111; p_reg=16.
- Synchroniser: rx_sync = RX_IN delayed SYNC_STAGES clocks. All counting and sampling uses rx_sync.
- Prescale latch:
  - p_reg <= prescale on the cycle edge_bit_enable rises (0 to 1).
  - Any value other than 8 is treated as 16.
  - Changes to prescale while enabled are ignored.
- Edge counter:
  - While edge_bit_enable=0: edge_count=0, bit_count=0.
  - While enabled: edge_count increments every clock.
  - At edge_count==p_reg-1, edge_count wraps to 0 and bit_count increments in the same cycle.
  - bit_count saturates at 31; it never wraps.
- Sampling, only while data_sampler_enable=1, with h=p_reg/2:
  - Capture s0 at edge_count==h-1, s1 at h, s2 at h+1.
  - At edge_count==h+2: sampled_bit <= majority(s0,s1,s2), and sample_valid pulses high for exactly 1 cycle.
  - Latency: 1 clock after the s2 capture.
- If data_sampler_enable drops mid-bit: the partial samples are discarded, no sample_valid is produced, and sampled_bit holds its value.
- If edge_bit_enable drops mid-bit: counters clear on the next clock; any pending sample is cancelled.
- Simultaneous enable rise and prescale change: the latched value is the prescale present in that cycle.
- Reset mid-frame: every output returns to its reset value immediately.

Optional Feature:
Macro UART_RX_SAMPLER_GLITCH_FLAG_EN.
- Defined: sample_glitch is registered alongside sampled_bit.
  - It is 1 when s0,s1,s2 are not all equal.
  - It is valid only in the sample_valid cycle and cleared otherwise.
- Undefined: sample_glitch is tied to 0 and no comparison logic is built.

Decomposition:
- Package uart_rx_pkg:
  - PRESCALE_8=5'd8, PRESCALE_16=5'd16.
  - EDGE_CNT_W=4, BIT_CNT_W default.
  - IDLE_LEVEL=1'b1.
- Sub-module uart_rx_sync: a parameterised N-flop reset-to-1 synchroniser, instantiated once for RX_IN.

Test Plan:
- Reset with RX_IN=0 -> all outputs at reset values; after release rx_sync goes 0 two clocks later (SYNC_STAGES=2).
- prescale=8, enable held for 24 clocks -> edge_count runs 0..7 three times; bit_count goes 1, 2, 3 on the cycles edge_count wraps from 7 to 0.
- prescale=16, clean bit 0 -> samples taken at edge_count 7, 8, 9; sampled_bit=0 with sample_valid pulsed exactly at edge_count==10.
- prescale=16, rx_sync = 0,1,0 at edges 7, 8, 9 -> sampled_bit=0; sample_glitch=1 with the macro defined, 0 without it.
- prescale changed from 16 to 8 mid-frame -> wrap point stays at 15 until edge_bit_enable toggles low then high.
- edge_bit_enable dropped at edge_count==8, then asy_reset pulsed mid-frame -> no sample_valid; counters at 0; reset values restored asynchronously.
